// File: rtl/writeback_stage.sv
// Dual-lane writeback stage: registers the retiring instruction pair,
// aligns load data, resolves same-register write collisions in favour of
// the younger lane, and counts retired instructions.
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid_1,
  input  logic        in_valid_2,
  input  logic        in_w_en_1,
  input  logic        in_w_en_2,
  input  logic [4:0]  in_w_addr_1,
  input  logic [4:0]  in_w_addr_2,
  input  logic [31:0] in_alu_data_1,
  input  logic [31:0] in_alu_data_2,
  input  logic        in_mem_to_reg_1,
  input  logic        in_mem_to_reg_2,
  input  logic [2:0]  in_load_type_1,
  input  logic [2:0]  in_load_type_2,
  input  logic [1:0]  in_addr_low_1,
  input  logic [1:0]  in_addr_low_2,
  input  logic [31:0] in_mem_rdata_1,
  input  logic [31:0] in_mem_rdata_2,
  output logic        reg_w_en_1,
  output logic        reg_w_en_2,
  output logic [4:0]  reg_w_addr_1,
  output logic [4:0]  reg_w_addr_2,
  output logic [31:0] reg_w_data_1,
  output logic [31:0] reg_w_data_2,
  output logic        wb_valid_1,
  output logic        wb_valid_2,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_type_e;

  logic        reg_w_en_1_q,   reg_w_en_1_d;
  logic        reg_w_en_2_q,   reg_w_en_2_d;
  logic [4:0]  reg_w_addr_1_q, reg_w_addr_1_d;
  logic [4:0]  reg_w_addr_2_q, reg_w_addr_2_d;
  logic [31:0] reg_w_data_1_q, reg_w_data_1_d;
  logic [31:0] reg_w_data_2_q, reg_w_data_2_d;
  logic        wb_valid_1_q,   wb_valid_1_d;
  logic        wb_valid_2_q,   wb_valid_2_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic        capEn1;
  logic        capEn2;
  logic [31:0] capData1;
  logic [31:0] capData2;

  // Byte/halfword extraction from a little-endian word; unknown types pass the word through.
  function automatic logic [31:0] alignLoad(input logic [2:0]  loadType,
                                            input logic [1:0]  addrLow,
                                            input logic [31:0] rdata);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] result;
    case (addrLow)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    halfSel = addrLow[1] ? rdata[31:16] : rdata[15:0];
    case (loadType)
      LOAD_LB:  result = {{24{byteSel[7]}}, byteSel};
      LOAD_LBU: result = {24'd0, byteSel};
      LOAD_LH:  result = {{16{halfSel[15]}}, halfSel};
      LOAD_LHU: result = {16'd0, halfSel};
      default:  result = rdata;
    endcase
    return result;
  endfunction

  // Values a capture would load: write enables with the r0 filter and collision rule, plus selected data.
  always_comb begin
    capEn2   = in_valid_2 & in_w_en_2 & (in_w_addr_2 != 5'd0);
    capEn1   = in_valid_1 & in_w_en_1 & (in_w_addr_1 != 5'd0)
               & ~(capEn2 & (in_w_addr_1 == in_w_addr_2));
    capData1 = in_mem_to_reg_1 ? alignLoad(in_load_type_1, in_addr_low_1, in_mem_rdata_1)
                               : in_alu_data_1;
    capData2 = in_mem_to_reg_2 ? alignLoad(in_load_type_2, in_addr_low_2, in_mem_rdata_2)
                               : in_alu_data_2;
  end

  // Next-state selection: flush kills the pair, stall holds everything, otherwise capture.
  always_comb begin
    reg_w_en_1_d   = reg_w_en_1_q;
    reg_w_en_2_d   = reg_w_en_2_q;
    reg_w_addr_1_d = reg_w_addr_1_q;
    reg_w_addr_2_d = reg_w_addr_2_q;
    reg_w_data_1_d = reg_w_data_1_q;
    reg_w_data_2_d = reg_w_data_2_q;
    wb_valid_1_d   = wb_valid_1_q;
    wb_valid_2_d   = wb_valid_2_q;
    retire_count_d = retire_count_q;
    if (flush) begin
      reg_w_en_1_d = 1'b0;
      reg_w_en_2_d = 1'b0;
      wb_valid_1_d = 1'b0;
      wb_valid_2_d = 1'b0;
    end else if (!stall) begin
      reg_w_en_1_d   = capEn1;
      reg_w_en_2_d   = capEn2;
      reg_w_addr_1_d = in_w_addr_1;
      reg_w_addr_2_d = in_w_addr_2;
      reg_w_data_1_d = capData1;
      reg_w_data_2_d = capData2;
      wb_valid_1_d   = in_valid_1;
      wb_valid_2_d   = in_valid_2;
      retire_count_d = retire_count_q + {31'd0, in_valid_1} + {31'd0, in_valid_2};
    end
  end

  // Output registers with synchronous reset clearing every field.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_w_en_1_q   <= 1'b0;
      reg_w_en_2_q   <= 1'b0;
      reg_w_addr_1_q <= 5'd0;
      reg_w_addr_2_q <= 5'd0;
      reg_w_data_1_q <= 32'd0;
      reg_w_data_2_q <= 32'd0;
      wb_valid_1_q   <= 1'b0;
      wb_valid_2_q   <= 1'b0;
      retire_count_q <= 32'd0;
    end else begin
      reg_w_en_1_q   <= reg_w_en_1_d;
      reg_w_en_2_q   <= reg_w_en_2_d;
      reg_w_addr_1_q <= reg_w_addr_1_d;
      reg_w_addr_2_q <= reg_w_addr_2_d;
      reg_w_data_1_q <= reg_w_data_1_d;
      reg_w_data_2_q <= reg_w_data_2_d;
      wb_valid_1_q   <= wb_valid_1_d;
      wb_valid_2_q   <= wb_valid_2_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign reg_w_en_1   = reg_w_en_1_q;
  assign reg_w_en_2   = reg_w_en_2_q;
  assign reg_w_addr_1 = reg_w_addr_1_q;
  assign reg_w_addr_2 = reg_w_addr_2_q;
  assign reg_w_data_1 = reg_w_data_1_q;
  assign reg_w_data_2 = reg_w_data_2_q;
  assign wb_valid_1   = wb_valid_1_q;
  assign wb_valid_2   = wb_valid_2_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage with hand-written
// sequences for stall/flush, counter wrap and reset-during-stall.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid_1, in_valid_2;
  logic        in_w_en_1, in_w_en_2;
  logic [4:0]  in_w_addr_1, in_w_addr_2;
  logic [31:0] in_alu_data_1, in_alu_data_2;
  logic        in_mem_to_reg_1, in_mem_to_reg_2;
  logic [2:0]  in_load_type_1, in_load_type_2;
  logic [1:0]  in_addr_low_1, in_addr_low_2;
  logic [31:0] in_mem_rdata_1, in_mem_rdata_2;
  logic        reg_w_en_1, reg_w_en_2;
  logic [4:0]  reg_w_addr_1, reg_w_addr_2;
  logic [31:0] reg_w_data_1, reg_w_data_2;
  logic        wb_valid_1, wb_valid_2;
  logic [31:0] retire_count;

  int compared;
  int mismatched;
  logic [31:0] expCount;

  typedef struct {
    logic        v;
    logic        w;
    logic [4:0]  a;
    logic [31:0] alu;
    logic        m;
    logic [2:0]  t;
    logic [1:0]  lo;
    logic [31:0] rd;
  } lane_t;

  typedef struct {
    logic        en;
    logic        val;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    lane_t l1;
    lane_t l2;
    exp_t  e1;
    exp_t  e2;
    int    inc;
  } vec_t;

  vec_t vecs[8];

  writeback_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .in_valid_1      (in_valid_1),
    .in_valid_2      (in_valid_2),
    .in_w_en_1       (in_w_en_1),
    .in_w_en_2       (in_w_en_2),
    .in_w_addr_1     (in_w_addr_1),
    .in_w_addr_2     (in_w_addr_2),
    .in_alu_data_1   (in_alu_data_1),
    .in_alu_data_2   (in_alu_data_2),
    .in_mem_to_reg_1 (in_mem_to_reg_1),
    .in_mem_to_reg_2 (in_mem_to_reg_2),
    .in_load_type_1  (in_load_type_1),
    .in_load_type_2  (in_load_type_2),
    .in_addr_low_1   (in_addr_low_1),
    .in_addr_low_2   (in_addr_low_2),
    .in_mem_rdata_1  (in_mem_rdata_1),
    .in_mem_rdata_2  (in_mem_rdata_2),
    .reg_w_en_1      (reg_w_en_1),
    .reg_w_en_2      (reg_w_en_2),
    .reg_w_addr_1    (reg_w_addr_1),
    .reg_w_addr_2    (reg_w_addr_2),
    .reg_w_data_1    (reg_w_data_1),
    .reg_w_data_2    (reg_w_data_2),
    .wb_valid_1      (wb_valid_1),
    .wb_valid_2      (wb_valid_2),
    .retire_count    (retire_count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input lane_t l1, input lane_t l2);
    in_valid_1      = l1.v;   in_valid_2      = l2.v;
    in_w_en_1       = l1.w;   in_w_en_2       = l2.w;
    in_w_addr_1     = l1.a;   in_w_addr_2     = l2.a;
    in_alu_data_1   = l1.alu; in_alu_data_2   = l2.alu;
    in_mem_to_reg_1 = l1.m;   in_mem_to_reg_2 = l2.m;
    in_load_type_1  = l1.t;   in_load_type_2  = l2.t;
    in_addr_low_1   = l1.lo;  in_addr_low_2   = l2.lo;
    in_mem_rdata_1  = l1.rd;  in_mem_rdata_2  = l2.rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e1, input exp_t e2);
    checkOutput({tag, " en1"},   {31'd0, reg_w_en_1},   {31'd0, e1.en});
    checkOutput({tag, " en2"},   {31'd0, reg_w_en_2},   {31'd0, e2.en});
    checkOutput({tag, " val1"},  {31'd0, wb_valid_1},   {31'd0, e1.val});
    checkOutput({tag, " val2"},  {31'd0, wb_valid_2},   {31'd0, e2.val});
    checkOutput({tag, " addr1"}, {27'd0, reg_w_addr_1}, {27'd0, e1.a});
    checkOutput({tag, " addr2"}, {27'd0, reg_w_addr_2}, {27'd0, e2.a});
    checkOutput({tag, " data1"}, reg_w_data_1,          e1.d);
    checkOutput({tag, " data2"}, reg_w_data_2,          e2.d);
    checkOutput({tag, " count"}, retire_count,          expCount);
  endtask

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin
    lane_t idle;
    lane_t la, lb;
    exp_t  zeroExp;
    exp_t  ea, eb;

    compared   = 0;
    mismatched = 0;
    idle    = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, 32'd0};
    zeroExp = '{1'b0, 1'b0, 5'd0, 32'd0};

    // ALU writeback on lane 1 only
    vecs[0] = '{'{1, 1, 5, 32'h12345678, 0, 0, 0, 0}, idle,
                '{1, 1, 5, 32'h12345678}, '{0, 0, 0, 0}, 1};
    // LB addr_low=3 / LBU addr_low=2
    vecs[1] = '{'{1, 1, 3, 32'h0, 1, 1, 3, RD}, '{1, 1, 4, 32'h0, 1, 2, 2, RD},
                '{1, 1, 3, 32'hFFFFFF80}, '{1, 1, 4, 32'h000000FF}, 2};
    // LH addr_low=2 / LHU addr_low=0
    vecs[2] = '{'{1, 1, 6, 32'h0, 1, 3, 2, RD}, '{1, 1, 7, 32'h0, 1, 4, 0, RD},
                '{1, 1, 6, 32'hFFFF80FF}, '{1, 1, 7, 32'h00007F01}, 2};
    // Same destination: lane 2 wins
    vecs[3] = '{'{1, 1, 9, 32'hA, 0, 0, 0, 0}, '{1, 1, 9, 32'hB, 0, 0, 0, 0},
                '{0, 1, 9, 32'hA}, '{1, 1, 9, 32'hB}, 2};
    // Both to r0: no writes, still retired
    vecs[4] = '{'{1, 1, 0, 32'hA, 0, 0, 0, 0}, '{1, 1, 0, 32'hB, 0, 0, 0, 0},
                '{0, 1, 0, 32'hA}, '{0, 1, 0, 32'hB}, 2};
    // Invalid lanes with w_en set never write
    vecs[5] = '{'{0, 1, 10, 32'h55, 0, 0, 0, 0}, '{0, 1, 11, 32'h66, 0, 0, 0, 0},
                '{0, 0, 10, 32'h55}, '{0, 0, 11, 32'h66}, 0};
    // LB positive byte at addr_low=1 / LH with addr_low[0] set
    vecs[6] = '{'{1, 1, 12, 32'h0, 1, 1, 1, RD}, '{1, 1, 13, 32'h0, 1, 3, 3, 32'hDEADBEEF},
                '{1, 1, 12, 32'h0000007F}, '{1, 1, 13, 32'hFFFFDEAD}, 2};
    // LW with w_en=0 / reserved load type passes word through
    vecs[7] = '{'{1, 0, 14, 32'h0, 1, 0, 1, RD}, '{1, 1, 15, 32'h0, 1, 6, 1, 32'hDEADBEEF},
                '{0, 1, 14, RD}, '{1, 1, 15, 32'hDEADBEEF}, 2};

    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(idle, idle);
    expCount = 32'd0;

    @(negedge clk);
    @(negedge clk);
    checkAll("reset", zeroExp, zeroExp);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].l1, vecs[i].l2);
      @(negedge clk);
      expCount = expCount + 32'(vecs[i].inc);
      checkAll($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
    end

    // Capture a valid pair, then stall with changing inputs
    la = '{1, 1, 20, 32'h111, 0, 0, 0, 0};
    lb = '{1, 1, 21, 32'h222, 0, 0, 0, 0};
    applyStimulus(la, lb);
    @(negedge clk);
    expCount = expCount + 32'd2;
    ea = '{1, 1, 20, 32'h111};
    eb = '{1, 1, 21, 32'h222};
    checkAll("pair", ea, eb);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus('{1, 1, 5'(i + 1), 32'h900 + 32'(i), 0, 0, 0, 0},
                    '{1, 1, 5'(i + 24), 32'hA00 + 32'(i), 0, 0, 0, 0});
      @(negedge clk);
      checkAll($sformatf("stall%0d", i), ea, eb);
    end

    // Flush while stalled: valids and enables drop, count holds
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush en1",   {31'd0, reg_w_en_1}, 32'd0);
    checkOutput("flush en2",   {31'd0, reg_w_en_2}, 32'd0);
    checkOutput("flush val1",  {31'd0, wb_valid_1}, 32'd0);
    checkOutput("flush val2",  {31'd0, wb_valid_2}, 32'd0);
    checkOutput("flush count", retire_count, expCount);
    flush = 1'b0;
    stall = 1'b0;

    // Counter wrap: preload all-ones while stalled, then retire two
    stall = 1'b1;
    applyStimulus(la, lb);
    force dut.retire_count_q = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("preload count", retire_count, 32'hFFFFFFFF);
    release dut.retire_count_q;
    stall = 1'b0;
    @(negedge clk);
    expCount = 32'h00000001;
    checkOutput("wrap count", retire_count, expCount);
    checkOutput("wrap val2", {31'd0, wb_valid_2}, 32'd1);

    // Reset during stall wins, then first capture only once stall drops
    stall = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    expCount = 32'd0;
    checkAll("rst-stall", zeroExp, zeroExp);
    reset = 1'b0;
    @(negedge clk);
    checkAll("post-rst-stall", zeroExp, zeroExp);
    stall = 1'b0;
    applyStimulus(la, idle);
    @(negedge clk);
    expCount = 32'd1;
    checkAll("first-capture", '{1, 1, 20, 32'h111}, zeroExp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
